// File: rtl/da_rom_player.sv
// rtl/da_rom_player.sv - DDS-style waveform ROM sequencer with stall-aware valid/ready output
module da_rom_player #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8,
  parameter int PHASE_WIDTH = 32,
  parameter int ROM_LATENCY = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [PHASE_WIDTH-1:0] cfg_freq_word,
  input  logic [ADDR_WIDTH-1:0]  cfg_phase_off,
  input  logic [CNT_WIDTH-1:0]   cfg_burst_len,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  output logic                   rom_clk_en,
  input  logic [DATA_WIDTH-1:0]  rom_rd_data,
  output logic [DATA_WIDTH-1:0]  dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] freq_q, freq_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   burst_q, burst_d;
  logic [ROM_LATENCY-1:0] vp_q, vp_d;
  logic                   done_q, done_d;

  logic                   stall;
  logic                   issue;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  // The ROM output itself is the sample register; holding its clock enable
  // freezes the whole read pipeline so a stalled sample stays on dout.
  assign dout_valid = vp_q[ROM_LATENCY-1];
  assign stall      = dout_valid & ~dout_ready;
  assign rom_clk_en = ~stall;
  assign issue      = (state_q == RUN) & ~stall;
  assign rom_addr   = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign dout       = rom_rd_data;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign cnt_inc    = cnt_q + CNT_WIDTH'(1);

  // Next-state logic: FSM, phase accumulator, burst counter and valid pipe.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    freq_d  = freq_q;
    cnt_d   = cnt_q;
    burst_d = burst_q;
    vp_d    = vp_q;
    done_d  = 1'b0;

    // Valid pipe mirrors the ROM read latency and stalls with it.
    if (!stall) begin
      vp_d[0] = issue;
      for (int i = 1; i < ROM_LATENCY; i++) begin
        vp_d[i] = vp_q[i-1];
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          freq_d  = cfg_freq_word;
          burst_d = cfg_burst_len;
          phase_d = '0;
          phase_d[PHASE_WIDTH-1 -: ADDR_WIDTH] = cfg_phase_off;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          phase_d = phase_q + freq_q;
          cnt_d   = cnt_inc;
        end
        // Stop wins, but a sample issued in the stop cycle is already in
        // the valid pipe and will still be delivered during DRAIN.
        if (stop || (issue && (burst_q != '0) && (cnt_inc == burst_q))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((vp_q == '0) && !stall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // With the pipe empty dout_valid is low, so no stall can block the exit:
    // done is high exactly in the DRAIN cycle that returns to IDLE.
    done_d = (state_d == DRAIN) && (vp_d == '0);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      freq_q  <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      vp_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      freq_q  <= freq_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      vp_q    <= vp_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_da_rom_player.sv
// tb/tb_da_rom_player.sv - scoreboard bench for da_rom_player with a two-stage ROM model
module tb_da_rom_player;

  localparam int AW = 10;
  localparam int DW = 10;
  localparam int PW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [PW-1:0] cfg_freq_word;
  logic [AW-1:0] cfg_phase_off;
  logic [CW-1:0] cfg_burst_len;
  logic [AW-1:0] rom_addr;
  logic          rom_clk_en;
  logic [DW-1:0] rom_rd_data;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic          busy;
  logic          done;

  int passed = 0;
  int total  = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  // ROM with output register: ROM[a] = a, both stages gated by clk_en.
  logic [DW-1:0] rom_s1 = '0;
  logic [DW-1:0] rom_s2 = '0;
  always_ff @(posedge clk) begin
    if (rom_clk_en) begin
      rom_s1 <= rom_addr;
      rom_s2 <= rom_s1;
    end
  end
  assign rom_rd_data = rom_s2;

  da_rom_player #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PHASE_WIDTH(PW), .ROM_LATENCY(2), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_freq_word(cfg_freq_word), .cfg_phase_off(cfg_phase_off), .cfg_burst_len(cfg_burst_len),
    .rom_addr(rom_addr), .rom_clk_en(rom_clk_en), .rom_rd_data(rom_rd_data),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic push_seq(input int first, input int step2, input int n, input int wrap);
    // step2 is the address step in half-address units
    for (int i = 0; i < n; i++) exp_q.push_back(DW'((first + (i * step2) / 2) % wrap));
  endtask

  // Starts playback at the current negedge (cycle 0) and scoreboards the output.
  task automatic play(input logic [PW-1:0] freq, input logic [AW-1:0] off, input logic [CW-1:0] burst,
                      input int stop_at, input int restart_at, input int stall_val, input int stall_len,
                      input int exp_beats, input int exp_done);
    int first_valid = -1;
    int done_cyc    = -1;
    int low_cyc     = -1;
    int beats       = 0;
    int stall_left  = 0;
    bit stalled     = 0;
    cfg_freq_word = freq;
    cfg_phase_off = off;
    cfg_burst_len = burst;
    start = 1'b1;
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      stop  = (c == stop_at);
      if (stall_val >= 0 && !stalled && dout_valid && int'(dout) == stall_val) begin
        stalled    = 1;
        stall_left = stall_len;
      end
      dout_ready = (stall_left == 0);
      #1;
      if (c == 1) begin
        chk("first_addr", 32'(rom_addr), 32'(off));
        chk("clk_en_run", 32'(rom_clk_en), 1);
      end
      if (stall_left > 0) begin
        chk("stall_dout_hold", 32'(dout), 32'(stall_val));
        chk("stall_clk_en", 32'(rom_clk_en), 0);
        stall_left--;
      end
      if (dout_valid && dout_ready) begin
        if (first_valid < 0) first_valid = c;
        beats++;
        if (exp_q.size() == 0) chk("extra_beat", 32'(dout), 32'hFFFF_FFFF);
        else chk("dout", 32'(dout), 32'(exp_q.pop_front()));
      end
      if (done) done_cyc = c;
      if (!busy) begin
        low_cyc = c;
        break;
      end
    end
    dout_ready = 1'b1;
    chk("first_valid_cycle", 32'(first_valid), 3);
    chk("done_cycle", 32'(done_cyc), 32'(exp_done));
    chk("busy_low_cycle", 32'(low_cyc), 32'(exp_done + 1));
    chk("beat_count", 32'(beats), 32'(exp_beats));
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; dout_ready = 1'b1;
    cfg_freq_word = '0; cfg_phase_off = '0; cfg_burst_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_clk_en", 32'(rom_clk_en), 1);
    chk("rst_addr", 32'(rom_addr), 0);
    rst_n = 1'b1;

    // Stop while idle is ignored.
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    chk("idle_stop_busy", 32'(busy), 0);

    // Basic burst of 4 with a second start mid-burst that must be ignored.
    push_seq(0, 2, 4, 1024);
    play(32'd1 << 22, 10'd0, 16'd4, 0, 3, -1, 0, 4, 7);

    // Address wrap from the top of the ROM.
    @(negedge clk);
    push_seq(1022, 2, 4, 1024);
    play(32'd1 << 22, 10'd1022, 16'd4, 0, 0, -1, 0, 4, 7);

    // Backpressure for three cycles while sample 1 is presented.
    @(negedge clk);
    push_seq(0, 2, 4, 1024);
    play(32'd1 << 22, 10'd0, 16'd4, 0, 0, 1, 3, 4, 10);

    // Half-address step: each address repeats twice.
    @(negedge clk);
    push_seq(0, 1, 6, 1024);
    play(32'd1 << 21, 10'd0, 16'd6, 0, 0, -1, 0, 6, 9);

    // Continuous mode stopped 10 cycles after start.
    @(negedge clk);
    push_seq(5, 2, 10, 1024);
    play(32'd1 << 22, 10'd5, 16'd0, 10, 0, -1, 0, 10, 13);

    // Reset while a sample is valid aborts immediately without done.
    @(negedge clk);
    cfg_freq_word = 32'd1 << 22; cfg_phase_off = 10'd100; cfg_burst_len = 16'd0;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 20 && !dout_valid; c++) @(negedge clk);
    chk("pre_reset_valid", 32'(dout_valid), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(dout_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_addr", 32'(rom_addr), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
